// File: rtl/univ_shift_engine_if.sv
// Handshake/data bundle for univ_shift_engine: request side (load/start/controls)
// driven by the master, register state and status returned by the slave.
interface univ_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) ();
  // Requests are level-sampled on the rising edge: load and start are honoured
  // only in IDLE; busy/done report progress and there is no back-pressure.
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic             si;
  logic [WIDTH-1:0] PO;
  logic             so;
  logic             busy;
  logic             done;

  modport master (
    output load, load_value, start, dir, mode, amount, si,
    input  PO, so, busy, done
  );

  modport slave (
    input  load, load_value, start, dir, mode, amount, si,
    output PO, so, busy, done
  );
endinterface

// File: rtl/univ_shift_engine.sv
// Universal shift register: parallel load, then a multi-cycle sequence of 1-bit
// logical/arithmetic/rotate/serial-in steps in either direction.
module univ_shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  univ_shift_engine_if.slave bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             so_q, so_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      po_q    <= '0;
      so_q    <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      po_q    <= po_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    po_d    = po_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    fill    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // load wins; a simultaneous start is discarded, not deferred
        if (bus.load) begin
          po_d = bus.load_value;
        end else if (bus.start) begin
          if (bus.amount != '0) begin
            dir_d   = bus.dir;
            mode_d  = bus.mode;
            cnt_d   = bus.amount;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        unique case (mode_q)
          2'b00: fill = 1'b0;
          2'b01: fill = dir_q ? po_q[WIDTH-1] : 1'b0;
          2'b10: fill = dir_q ? po_q[0] : po_q[WIDTH-1];
          default: fill = bus.si;
        endcase
        if (!dir_q) begin
          po_d = {po_q[WIDTH-2:0], fill};
          so_d = po_q[WIDTH-1];
        end else begin
          po_d = {fill, po_q[WIDTH-1:1]};
          so_d = po_q[0];
        end
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.PO   = po_q;
  assign bus.so   = so_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Bench for univ_shift_engine (WIDTH=8): directed vector table, multi-cycle
// corner sequences, and random operations against an arithmetic shift model.
module tb_univ_shift_engine;
  localparam int W  = 8;
  localparam int AW = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         failures;
  logic [W-1:0] exp_q[$];
  logic         so_track;

  univ_shift_engine_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  univ_shift_engine #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result from the shift rules as whole-word arithmetic on amount n.
  task automatic model(input logic [W-1:0] v, input logic d, input logic [1:0] m,
                       input int n, input logic s, input logic so_prev,
                       output logic [W-1:0] po, output logic so);
    logic [W-1:0] ones;
    ones = W'((1 << n) - 1);
    if (n == 0) begin
      po = v;
      so = so_prev;
    end else if (!d) begin
      case (m)
        2'b00, 2'b01: po = v << n;
        2'b10:        po = (v << n) | (v >> (W - n));
        default:      po = (v << n) | (s ? ones : '0);
      endcase
      so = v[W-n];
    end else begin
      case (m)
        2'b00:   po = v >> n;
        2'b01:   po = W'($signed(v) >>> n);
        2'b10:   po = (v >> n) | (v << (W - n));
        default: po = (v >> n) | (s ? ~({W{1'b1}} >> n) : '0);
      endcase
      so = v[n-1];
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk);
    bus.load = 1'b1;
    bus.load_value = v;
    bus.start = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    check("load_po", 32'(bus.PO), 32'(v));
  endtask

  // Issues one start, scrambles the controls afterwards, optionally pokes load
  // while busy; returns busy cycles, done cycles and any busy/done overlap.
  task automatic run_op(input logic d, input logic [1:0] m, input logic [AW-1:0] n,
                        input logic s, input logic poke_load,
                        output int busy_cnt, output int done_cnt, output int overlap);
    @(negedge clk);
    bus.start = 1'b1; bus.load = 1'b0;
    bus.dir = d; bus.mode = m; bus.amount = n; bus.si = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dir = 1'($urandom); bus.mode = 2'($urandom); bus.amount = AW'($urandom);
    busy_cnt = 0; done_cnt = 0; overlap = 0;
    for (int c = 0; c < 2 * W + 4; c++) begin
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        bus.load = 1'b0;
        done_cnt++;
        @(negedge clk);
        if (bus.done) done_cnt++;
        if (bus.busy) overlap++;
        break;
      end
      if (bus.busy) begin
        busy_cnt++;
        if (poke_load) begin
          bus.load = 1'b1;
          bus.load_value = W'($urandom);
          bus.start = 1'($urandom);
        end
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    bus.start = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0]  ld;
    logic          d;
    logic [1:0]    m;
    logic [AW-1:0] n;
    logic          s;
    logic [W-1:0]  exp_po;
    logic          exp_so;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bc, dc, ov;
    logic [W-1:0] v, e_po, got;
    logic e_so, d, s;
    logic [1:0] m;
    logic [AW-1:0] n;

    checks = 0; failures = 0; so_track = 1'b0;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0;
    bus.dir = 1'b0; bus.mode = 2'b00; bus.amount = '0; bus.si = 1'b0;

    vecs[0] = '{8'hB4, 1'b0, 2'b00, 3'd3, 1'b0, 8'hA0, 1'b1};
    vecs[1] = '{8'h96, 1'b1, 2'b01, 3'd2, 1'b0, 8'hE5, 1'b1};
    vecs[2] = '{8'h81, 1'b0, 2'b10, 3'd1, 1'b0, 8'h03, 1'b1};
    vecs[3] = '{8'h81, 1'b1, 2'b10, 3'd7, 1'b0, 8'h03, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 2'b11, 3'd4, 1'b1, 8'hF0, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 2'b00, 3'd0, 1'b0, 8'h5A, 1'b0};
    vecs[6] = '{8'h0F, 1'b0, 2'b11, 3'd2, 1'b1, 8'h3F, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_po", 32'(bus.PO), 32'h0);
    check("reset_so", 32'(bus.so), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].ld);
      run_op(vecs[i].d, vecs[i].m, vecs[i].n, vecs[i].s, 1'b0, bc, dc, ov);
      check($sformatf("vec%0d_po", i), 32'(bus.PO), 32'(vecs[i].exp_po));
      check($sformatf("vec%0d_so", i), 32'(bus.so), 32'(vecs[i].exp_so));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].n));
      check($sformatf("vec%0d_done_cycles", i), 32'(dc), 32'd1);
      check($sformatf("vec%0d_overlap", i), 32'(ov), 32'd0);
    end
    so_track = 1'b0;

    // load and start together in IDLE: load taken, start dropped
    @(negedge clk);
    bus.load = 1'b1; bus.load_value = 8'h3C; bus.start = 1'b1;
    bus.dir = 1'b0; bus.mode = 2'b00; bus.amount = 3'd2;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    check("ldst_po", 32'(bus.PO), 32'h3C);
    check("ldst_done0", 32'(bus.done), 32'h0);
    check("ldst_busy0", 32'(bus.busy), 32'h0);
    @(negedge clk);
    check("ldst_done1", 32'(bus.done), 32'h0);
    check("ldst_busy1", 32'(bus.busy), 32'h0);

    // load during SHIFT is ignored
    do_load(8'hC3);
    run_op(1'b1, 2'b00, 3'd5, 1'b0, 1'b1, bc, dc, ov);
    check("ldshift_po", 32'(bus.PO), 32'h06);
    check("ldshift_busy_cycles", 32'(bc), 32'd5);
    check("ldshift_done_cycles", 32'(dc), 32'd1);

    // asynchronous reset during step 2 of a 5-step shift
    do_load(8'hB4);
    @(negedge clk);
    bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b00; bus.amount = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_po", 32'(bus.PO), 32'h0);
    check("mid_rst_so", 32'(bus.so), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    so_track = 1'b0;
    do_load(8'h77);

    // random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      v = W'($urandom);
      d = 1'($urandom);
      m = 2'($urandom);
      n = AW'($urandom_range(0, W - 1));
      s = 1'($urandom);
      model(v, d, m, int'(n), s, so_track, e_po, e_so);
      exp_q.push_back(e_po);
      do_load(v);
      run_op(d, m, n, s, 1'($urandom), bc, dc, ov);
      got = exp_q.pop_front();
      check($sformatf("rnd%0d_po", i), 32'(bus.PO), 32'(got));
      check($sformatf("rnd%0d_so", i), 32'(bus.so), 32'(e_so));
      check($sformatf("rnd%0d_busy_cycles", i), 32'(bc), 32'(n));
      check($sformatf("rnd%0d_done_cycles", i), 32'(dc), 32'd1);
      check($sformatf("rnd%0d_overlap", i), 32'(ov), 32'd0);
      so_track = e_so;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_engine.md
UNIV_SHIFT_ENGINE -- requirements
Module: univ_shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2 or greater.
REQ-002 SHALL have parameter AMT_W, default $clog2(WIDTH), width of the amount port.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load, input, 1, load request: PO <= load_value when honoured.
REQ-006 SHALL have port load_value, input, WIDTH, value to load.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a shift operation.
REQ-008 SHALL have port dir, input, 1, shift direction: 0 = left, 1 = right; sampled with start.
REQ-009 SHALL have port mode, input, 2, sampled with start: 00 logical, 01 arithmetic, 10 rotate, 11 serial-in.
REQ-010 SHALL have port amount, input, AMT_W, number of single-bit steps, 0..WIDTH-1; sampled with start.
REQ-011 SHALL have port si, input, 1, serial fill bit for mode 11; sampled every shift step.
REQ-012 SHALL have port PO, output, WIDTH, the register contents (parallel out).
REQ-013 SHALL have port so, output, 1, registered copy of the bit shifted out on the most recent step.
REQ-014 SHALL have port busy, output, 1, high while in the SHIFT state.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 In IDLE, load SHALL take priority: PO <= load_value, and a start in the same cycle SHALL be dropped.
REQ-018 In IDLE, start with load low and amount != 0 SHALL latch dir, mode and amount into an internal counter and go to SHIFT.
REQ-019 In IDLE, start with load low and amount == 0 SHALL go directly to DONE, with PO and so unchanged.
REQ-020 In SHIFT, each edge SHALL perform exactly one 1-bit step using the latched dir/mode, update so, and decrement the counter; on the step where the counter is 1, SHALL go to DONE.
REQ-021 Left-step fill rules: logical and arithmetic fill LSB with 0; rotate fills LSB with the old MSB; serial-in fills LSB with si; so = old MSB.
REQ-022 Right-step fill rules: logical fills MSB with 0; arithmetic replicates the old MSB; rotate fills MSB with the old LSB; serial-in fills MSB with si; so = old LSB.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 Latency: start sampled at edge k with amount N>0 SHALL give shifts on edges k+1..k+N, busy high for N cycles, and done high for the cycle following edge k+N; for N=0, done is high for the cycle following edge k.
REQ-025 load and start SHALL be ignored in SHIFT and DONE; PO changes only by shifting.
REQ-026 Changes to dir, mode, amount or si after start SHALL NOT affect an operation in progress, except that si is sampled per step.
REQ-027 busy and done SHALL never be high in the same cycle.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force PO=0, so=0, busy=0, done=0, counter=0 and state IDLE, regardless of clk, including mid-operation.
REQ-029 After rst_n deasserts, the first honoured request SHALL be taken on the next rising edge.

Verification (WIDTH=8)
REQ-030 Load 0xB4; start with dir=0, mode=00, amount=3 -> busy high 3 cycles, then PO=0xA0, so=1, done one cycle.
REQ-031 Load 0x96; start with dir=1, mode=01, amount=2 -> PO=0xE5, so=1.
REQ-032 Load 0x81; rotate left amount 1 -> PO=0x03; reload 0x81, rotate right amount 7 -> PO=0x03.
REQ-033 Load 0x00; mode=11, dir=1, si=1, amount=4 -> PO=0xF0, so=0.
REQ-034 Start with amount=0 -> done the next cycle, busy never high, PO unchanged; load and start together in IDLE -> PO=load_value and no done.
REQ-035 Pull rst_n low during step 2 of a 5-step shift -> PO, so, busy and done are 0 immediately; load during SHIFT leaves PO following the shift sequence.
